msrv32_load_requester: RTL

//  Read-side bus master for data loads. Takes the effective address produced by

---
 rtl/msrv32_pkg.sv | 30 +++
 rtl/msrv32_load_align.sv | 28 ++
 rtl/msrv32_load_requester.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared load-size codes, requester FSM encoding and the alignment rule used by
// the data-load path.
package msrv32_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        MIS  = 3'd4
    } load_state_e;

    // Size code 2'b11 has no dedicated instruction and is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Byte-lane select and sign/zero extension of a 32-bit read word for LB/LH/LW
// and their unsigned variants.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        byte_sel = rdata_in[8*offset_in +: 8];
        half_sel = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        data_out = rdata_in;
        case (size_in)
            LS_BYTE: data_out = {{24{byte_sel[7] & ~unsigned_in}}, byte_sel};
            LS_HALF: data_out = {{16{half_sel[15] & ~unsigned_in}}, half_sel};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_load_requester.sv
// Data-load bus master: word-aligned read request, wait for ack, return the
// extended result. Define LOAD_TIMEOUT_EN to add a bounded WAIT with fault pulse.
module msrv32_load_requester
    import msrv32_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_req_in,
    input  logic [ADDR_W-1:0] iadder_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    output logic              dm_req_out,
    output logic [ADDR_W-1:0] dm_addr_out,
    input  logic              dm_ack_in,
    input  logic [DATA_W-1:0] dm_rdata_in,
    output logic              load_busy_out,
    output logic              load_valid_out,
    output logic [DATA_W-1:0] load_data_out,
    output logic              misaligned_out,
    output logic              load_fault_out
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("msrv32_load_requester supports DATA_W = 32 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("msrv32_load_requester needs TIMEOUT_CYCLES >= 1");
    end

    load_state_e       state_q;
    logic              dm_req_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic              busy_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              mis_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [1:0]        offset_q;
    logic [DATA_W-1:0] data_d;

`ifdef LOAD_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
`endif

    // Extraction works from the request attributes latched in IDLE, not the live inputs.
    msrv32_load_align u_align (
        .rdata_in    (dm_rdata_in),
        .offset_in   (offset_q),
        .size_in     (size_q),
        .unsigned_in (unsigned_q),
        .data_out    (data_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_addr_q  <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            mis_q      <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            offset_q   <= 2'b00;
`ifdef LOAD_TIMEOUT_EN
            cnt_q      <= '0;
            fault_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (load_req_in) begin
                        if (is_misaligned(load_size_in, iadder_in[1:0])) begin
                            state_q <= MIS;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q    <= REQ;
                            dm_req_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            dm_addr_q  <= {iadder_in[ADDR_W-1:2], 2'b00};
                            size_q     <= load_size_in;
                            unsigned_q <= load_unsigned_in;
                            offset_q   <= iadder_in[1:0];
                        end
                    end
                end
                REQ: begin
                    state_q <= WAIT;
`ifdef LOAD_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
                    // An ack on the terminal timeout cycle still completes the load.
                    if (dm_ack_in) begin
                        state_q  <= RESP;
                        dm_req_q <= 1'b0;
                        data_q   <= data_d;
                        valid_q  <= 1'b1;
                    end
`ifdef LOAD_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        state_q  <= IDLE;
                        dm_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        fault_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                MIS: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    dm_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req_out     = dm_req_q;
    assign dm_addr_out    = dm_addr_q;
    assign load_busy_out  = busy_q;
    assign load_valid_out = valid_q;
    assign load_data_out  = data_q;
    assign misaligned_out = mis_q;
`ifdef LOAD_TIMEOUT_EN
    assign load_fault_out = fault_q;
`else
    assign load_fault_out = 1'b0;
`endif

endmodule
